// File: rtl/phase_monitor_if.sv
// Signal bundle between a phase source and phase_monitor.
// master: drives the phase lines and controls and observes the status.
// slave:  the monitor, which samples the phases and drives the status.
interface phase_monitor_if #(
  parameter int CNT_W = 16
);
  logic             ph0;
  logic             ph1;
  logic             ph2;
  logic             test;
  logic             clear_err;
  logic             locked;
  logic             err;
  logic [1:0]       err_code;
  logic [1:0]       cur_phase;
  logic             instr_done;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output ph0, ph1, ph2, test, clear_err,
    input  locked, err, err_code, cur_phase, instr_done, instr_cnt
  );

  modport slave (
    input  ph0, ph1, ph2, test, clear_err,
    output locked, err, err_code, cur_phase, instr_done, instr_cnt
  );
endinterface

// File: rtl/phase_monitor.sv
// phase_monitor: checks that three one-hot phase lines rotate
// ph1 -> ph2 -> ph0 -> ph1, locks after LOCK_N correct transitions, latches
// the first fault with a reason code and counts completed rotations.
// All outputs are registered (one cycle behind the sample).
// Optional feature: define PHASE_MON_CNT_EN to build the rotation counter;
// without it instr_cnt is tied to zero.
module phase_monitor #(
  parameter int CNT_W  = 16,
  parameter int LOCK_N = 2
) (
  input logic            clk,
  input logic            reset,
  phase_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam logic [1:0] PH_NONE = 2'd3;
  localparam logic [1:0] CODE_ILLEGAL = 2'd1;
  localparam logic [1:0] CODE_SEQ     = 2'd2;
  localparam logic [1:0] CODE_STUCK   = 2'd3;

  state_t     state_reg;
  logic [3:0] match_reg;
  logic [1:0] expect_reg;
  logic [1:0] cur_phase_reg;
  logic [1:0] err_code_reg;
  logic       locked_reg;
  logic       err_reg;
  logic       instr_done_reg;

  logic [1:0] sample;
  logic [1:0] succ;
  logic       done_hit;

  // Decode the phase lines into a phase number and its legal successor
  always_comb begin
    sample = PH_NONE;
    case ({bus.ph2, bus.ph1, bus.ph0})
      3'b001:  sample = 2'd0;
      3'b010:  sample = 2'd1;
      3'b100:  sample = 2'd2;
      default: sample = PH_NONE;
    endcase
    succ = (sample == 2'd2) ? 2'd0 : sample + 2'd1;
    // A correct ph0 while already locked completes one rotation
    done_hit = (state_reg == LOCKED) && !bus.test && (sample == 2'd0) &&
               (expect_reg == 2'd0) && (cur_phase_reg != 2'd0);
  end

  // Rotation-check FSM with registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      match_reg      <= 4'd0;
      expect_reg     <= 2'd0;
      cur_phase_reg  <= PH_NONE;
      err_code_reg   <= 2'd0;
      locked_reg     <= 1'b0;
      err_reg        <= 1'b0;
      instr_done_reg <= 1'b0;
    end else begin
      cur_phase_reg  <= sample;
      instr_done_reg <= done_hit;
      if (state_reg == FAULT) begin
        // clear_err wins over test; otherwise the fault is sticky
        if (bus.clear_err) begin
          state_reg    <= IDLE;
          err_reg      <= 1'b0;
          err_code_reg <= 2'd0;
        end
      end else if (!bus.test) begin
        if (state_reg == IDLE) begin
          if (sample == PH_NONE) begin
            state_reg    <= FAULT;
            err_reg      <= 1'b1;
            err_code_reg <= CODE_ILLEGAL;
            locked_reg   <= 1'b0;
          end else begin
            state_reg  <= TRACK;
            match_reg  <= 4'd0;
            expect_reg <= succ;
          end
        end else if (sample == PH_NONE) begin
          state_reg    <= FAULT;
          err_reg      <= 1'b1;
          err_code_reg <= CODE_ILLEGAL;
          locked_reg   <= 1'b0;
        end else if (sample == cur_phase_reg) begin
          state_reg    <= FAULT;
          err_reg      <= 1'b1;
          err_code_reg <= CODE_STUCK;
          locked_reg   <= 1'b0;
        end else if (sample != expect_reg) begin
          state_reg    <= FAULT;
          err_reg      <= 1'b1;
          err_code_reg <= CODE_SEQ;
          locked_reg   <= 1'b0;
        end else begin
          expect_reg <= succ;
          if (state_reg == TRACK) begin
            match_reg <= match_reg + 4'd1;
            if (match_reg + 4'd1 == 4'(LOCK_N)) begin
              state_reg  <= LOCKED;
              locked_reg <= 1'b1;
            end
          end
        end
      end
    end
  end

`ifdef PHASE_MON_CNT_EN
  logic [CNT_W-1:0] instr_cnt_reg;

  // Completed-rotation counter, wraps naturally at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_cnt_reg <= '0;
    end else if (done_hit) begin
      instr_cnt_reg <= instr_cnt_reg + CNT_W'(1);
    end
  end

  assign bus.instr_cnt = instr_cnt_reg;
`else
  assign bus.instr_cnt = {CNT_W{1'b0}};
`endif

  assign bus.locked     = locked_reg;
  assign bus.err        = err_reg;
  assign bus.err_code   = err_code_reg;
  assign bus.cur_phase  = cur_phase_reg;
  assign bus.instr_done = instr_done_reg;

endmodule

// File: tb/tb_phase_monitor.sv
// Bench for phase_monitor (LOCK_N=2, CNT_W=4): a directed vector table,
// hand-written corner sequences and a randomized run, all compared against
// a rule-level reference model kept here.
module tb_phase_monitor;
  localparam int CNT_W  = 4;
  localparam int LOCK_N = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  phase_monitor_if #(.CNT_W(CNT_W)) bus ();

  phase_monitor #(.CNT_W(CNT_W), .LOCK_N(LOCK_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: rule-level history of the rotation
  int m_last;    // last sampled phase, 3 = none/illegal
  int m_streak;  // correct transitions since a legal start, -1 = no start
  int m_anchor;  // last accepted phase
  int m_code;    // latched fault code, 0 = no fault
  int m_cnt;     // completed rotations
  bit m_done;

  function automatic int cnt_view(input int c);
`ifdef PHASE_MON_CNT_EN
    return c % (1 << CNT_W);
`else
    return 0 * c;
`endif
  endfunction

  function automatic int phase_of(input logic [2:0] ph);
    if ($countones(ph) != 1) return 3;
    for (int k = 0; k < 3; k++) if (ph[k]) return k;
    return 3;
  endfunction

  task automatic m_reset();
    m_last = 3; m_streak = -1; m_anchor = 0; m_code = 0; m_cnt = 0; m_done = 0;
  endtask

  task automatic m_step(input logic [2:0] ph, input logic t, input logic c);
    int p;
    p = phase_of(ph);
    m_done = 0;
    if (m_code != 0) begin
      if (c) begin m_code = 0; m_streak = -1; end
    end else if (!t) begin
      if (m_streak < 0) begin
        if (p == 3) m_code = 1;
        else begin m_streak = 0; m_anchor = p; end
      end else if (p == 3) m_code = 1;
      else if (p == m_last) m_code = 3;
      else if (p != (m_anchor + 1) % 3) m_code = 2;
      else begin
        if (m_streak >= LOCK_N && p == 0) begin m_done = 1; m_cnt++; end
        if (m_streak < LOCK_N) m_streak++;
        m_anchor = p;
      end
    end
    m_last = p;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".locked"},    32'(bus.locked),    32'((m_code == 0) && (m_streak >= LOCK_N)));
    check({tag, ".err"},       32'(bus.err),       32'(m_code != 0));
    check({tag, ".err_code"},  32'(bus.err_code),  32'(m_code));
    check({tag, ".cur_phase"}, 32'(bus.cur_phase), 32'(m_last));
    check({tag, ".done"},      32'(bus.instr_done), 32'(m_done));
    check({tag, ".cnt"},       32'(bus.instr_cnt), 32'(cnt_view(m_cnt)));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".locked"},    32'(bus.locked),     0);
    check({tag, ".err"},       32'(bus.err),        0);
    check({tag, ".err_code"},  32'(bus.err_code),   0);
    check({tag, ".cur_phase"}, 32'(bus.cur_phase),  3);
    check({tag, ".done"},      32'(bus.instr_done), 0);
    check({tag, ".cnt"},       32'(bus.instr_cnt),  0);
  endtask

  // One clock: drive, take the edge, sample 1 time unit later, compare with model
  task automatic step(input logic [2:0] ph, input logic t, input logic c, input string tag);
    bus.ph0 = ph[0]; bus.ph1 = ph[1]; bus.ph2 = ph[2];
    bus.test = t; bus.clear_err = c;
    @(posedge clk);
    #1;
    m_step(ph, t, c);
    check_model(tag);
    $display("%s ph=%b test=%b clr=%b -> locked=%b err=%b code=%0d phase=%0d done=%b cnt=%0d",
             tag, ph, t, c, bus.locked, bus.err, bus.err_code, bus.cur_phase,
             bus.instr_done, bus.instr_cnt);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    m_reset();
    check_reset_values({tag, ".async"});
    @(posedge clk);
    #1;
    check_reset_values({tag, ".held"});
    reset = 1'b0;
  endtask

  typedef struct {
    logic [2:0] ph;
    logic       t;
    logic       c;
    logic       lk;
    logic       er;
    logic [1:0] code;
    logic [1:0] phs;
    logic       dn;
    int         cnt;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [2:0] ph;
    logic t, c;
    int before_cnt;

    // lock, first rotation, illegal fault, stuck, out-of-sequence, clear vs test
    tbl[0]  = '{3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 0};
    tbl[1]  = '{3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 0};
    tbl[2]  = '{3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 0};
    tbl[3]  = '{3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 0};
    tbl[4]  = '{3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 0};
    tbl[5]  = '{3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1};
    tbl[6]  = '{3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd3, 1'b0, 1};
    tbl[7]  = '{3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 1'b0, 1};
    tbl[8]  = '{3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 1};
    tbl[9]  = '{3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 1};
    tbl[10] = '{3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd1, 1'b0, 1};
    tbl[11] = '{3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 1};
    tbl[12] = '{3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 1};
    tbl[13] = '{3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 1};
    tbl[14] = '{3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 1};
    tbl[15] = '{3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1};
    tbl[16] = '{3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 1};
    tbl[17] = '{3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 1};

    bus.ph0 = 1'b0; bus.ph1 = 1'b0; bus.ph2 = 1'b0;
    bus.test = 1'b0; bus.clear_err = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].ph, tbl[i].t, tbl[i].c, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_locked", i), 32'(bus.locked),     32'(tbl[i].lk));
      check($sformatf("vec%0d.tbl_err", i),    32'(bus.err),        32'(tbl[i].er));
      check($sformatf("vec%0d.tbl_code", i),   32'(bus.err_code),   32'(tbl[i].code));
      check($sformatf("vec%0d.tbl_phase", i),  32'(bus.cur_phase),  32'(tbl[i].phs));
      check($sformatf("vec%0d.tbl_done", i),   32'(bus.instr_done), 32'(tbl[i].dn));
      check($sformatf("vec%0d.tbl_cnt", i),    32'(bus.instr_cnt),  32'(cnt_view(tbl[i].cnt)));
    end

    // Illegal pattern while locked, then the fault must hold for 10 cycles
    step(3'b011, 1'b0, 1'b0, "illegal");
    for (int i = 0; i < 10; i++) begin
      ph = 3'b001 << $urandom_range(0, 2);
      t = 1'($urandom_range(0, 1));
      step(ph, t, 1'b0, $sformatf("hold%0d", i));
      check("hold.err", 32'(bus.err), 1);
      check("hold.code", 32'(bus.err_code), 1);
      check("hold.locked", 32'(bus.locked), 0);
    end

    // Clear and relock in three edges
    step(3'b001, 1'b0, 1'b1, "clear");
    check("clear.err", 32'(bus.err), 0);
    step(3'b010, 1'b0, 1'b0, "relock1");
    step(3'b100, 1'b0, 1'b0, "relock2");
    step(3'b001, 1'b0, 1'b0, "relock3");
    check("relock.locked", 32'(bus.locked), 1);

    // Test freeze with a corrupted rotation
    before_cnt = m_cnt;
    begin
      logic [2:0] junk [6];
      junk = '{3'b011, 3'b010, 3'b010, 3'b111, 3'b000, 3'b100};
      for (int i = 0; i < 6; i++) begin
        step(junk[i], 1'b1, 1'b0, $sformatf("freeze%0d", i));
        check("freeze.err", 32'(bus.err), 0);
        check("freeze.done", 32'(bus.instr_done), 0);
        check("freeze.locked", 32'(bus.locked), 1);
        check("freeze.cnt", 32'(bus.instr_cnt), 32'(cnt_view(before_cnt)));
      end
    end
    step(3'b010, 1'b0, 1'b0, "resume1");
    step(3'b100, 1'b0, 1'b0, "resume2");
    step(3'b001, 1'b0, 1'b0, "resume3");
    check("resume.done", 32'(bus.instr_done), 1);

    // Counter wrap from a fresh reset: 16 rotations after lock
    do_reset("wrap_rst");
    step(3'b010, 1'b0, 1'b0, "wlock1");
    step(3'b100, 1'b0, 1'b0, "wlock2");
    step(3'b001, 1'b0, 1'b0, "wlock3");
    for (int r = 1; r <= 16; r++) begin
      step(3'b010, 1'b0, 1'b0, $sformatf("rot%0d.a", r));
      step(3'b100, 1'b0, 1'b0, $sformatf("rot%0d.b", r));
      step(3'b001, 1'b0, 1'b0, $sformatf("rot%0d.c", r));
      check("wrap.cnt", 32'(bus.instr_cnt), 32'(cnt_view(r)));
    end

    // Reset asserted mid-rotation, then first edge is an IDLE sample
    step(3'b010, 1'b0, 1'b0, "mid");
    do_reset("mid_rst");
    step(3'b100, 1'b0, 1'b0, "post_rst");
    check("post_rst.locked", 32'(bus.locked), 0);

    // Randomized run against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 85) begin
        if (m_streak >= 0 && m_code == 0)
          ph = 3'b001 << ((m_anchor + 1) % 3);
        else
          ph = 3'b001 << $urandom_range(0, 2);
      end else begin
        ph = 3'($urandom_range(0, 7));
      end
      t = ($urandom_range(0, 99) < 5);
      c = (m_code != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) < 3);
      step(ph, t, c, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
